// File: rtl/cordic_sequencer.sv
// Round-robin sequencer sharing one iterative CORDIC core between two phase channels.
// Optional WAIT watchdog is built when CORDIC_SEQ_TIMEOUT_EN is defined.
module cordic_sequencer #(
  parameter int PHASE_WIDTH    = 13,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*PHASE_WIDTH-1:0]  req_phase,
  input  logic [3:0]                req_quadrant,
  output logic                      core_start,
  output logic [PHASE_WIDTH-1:0]    core_phase,
  input  logic                      core_done,
  input  logic [DATA_WIDTH-1:0]     core_cos,
  input  logic [DATA_WIDTH-1:0]     core_sin,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [2*DATA_WIDTH-1:0]   rsp_cos,
  output logic [2*DATA_WIDTH-1:0]   rsp_sin,
  output logic                      core_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_t                state_reg, state_next;
  logic                  ptr_reg;
  logic                  ch_reg;
  logic [1:0]            quad_reg;
  logic [1:0]            eligible;
  logic                  grant;
  logic                  grant_ch;
  logic                  done_take;
  logic                  expire;
  logic                  write;
  logic [DATA_WIDTH-1:0] fold_cos, fold_sin;

  function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] x);
    return (x == MOST_NEG) ? MOST_POS : ((~x) + DATA_WIDTH'(1));
  endfunction

  // A channel with an unconsumed result may not start another job.
  assign eligible = req_valid & ~rsp_valid;

  always_comb begin
    grant_ch = eligible[1];
    if (eligible == 2'b11) grant_ch = ptr_reg;
  end

  assign grant     = (state_reg == IDLE) && (eligible != 2'b00);
  assign req_ready = grant ? (grant_ch ? 2'b10 : 2'b01) : 2'b00;
  assign done_take = (state_reg == WAIT) && core_done;
  assign write     = done_take || expire;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_reg;
  logic          timeout_reg;

  // core_done in the expiry cycle takes priority over the watchdog.
  assign expire = (state_reg == WAIT) && !core_done &&
                  (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if (state_reg == WAIT) wait_cnt_reg <= wait_cnt_reg + CW'(1);
      else                   wait_cnt_reg <= '0;
      if (expire) timeout_reg <= 1'b1;
    end
  end

  assign core_timeout = timeout_reg;
`else
  assign expire = 1'b0;
  // Watchdog not built; the limit parameter has no effect and the flag stays low.
  assign core_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next = state_reg;
    core_start = 1'b0;
    case (state_reg)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE: begin
        core_start = 1'b1;
        state_next = WAIT;
      end
      WAIT:    if (write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Quadrants II/III negate cos, III/IV negate sin; a watchdog expiry writes zeros.
  always_comb begin
    fold_cos = (quad_reg[0] ^ quad_reg[1]) ? neg_sat(core_cos) : core_cos;
    fold_sin = quad_reg[1] ? neg_sat(core_sin) : core_sin;
    if (!done_take) begin
      fold_cos = '0;
      fold_sin = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= 1'b0;
      ch_reg     <= 1'b0;
      quad_reg   <= 2'b00;
      core_phase <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        ptr_reg    <= ~grant_ch;
        ch_reg     <= grant_ch;
        quad_reg   <= grant_ch ? req_quadrant[3:2] : req_quadrant[1:0];
        core_phase <= grant_ch ? req_phase[2*PHASE_WIDTH-1:PHASE_WIDTH]
                               : req_phase[PHASE_WIDTH-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] cos_reg, sin_reg;
    logic                  valid_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cos_reg   <= '0;
        sin_reg   <= '0;
        valid_reg <= 1'b0;
      end else if (write && (ch_reg == 1'(gi))) begin
        cos_reg   <= fold_cos;
        sin_reg   <= fold_sin;
        valid_reg <= 1'b1;
      end else if (valid_reg && rsp_ready[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign rsp_cos[gi*DATA_WIDTH +: DATA_WIDTH] = cos_reg;
    assign rsp_sin[gi*DATA_WIDTH +: DATA_WIDTH] = sin_reg;
    assign rsp_valid[gi]                        = valid_reg;
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration/fold rules.
module tb_cordic_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [25:0] req_phase = '0;
  logic [3:0]  req_quadrant = '0;
  logic        core_start;
  logic [12:0] core_phase;
  logic        core_done = 1'b0;
  logic [15:0] core_cos = '0;
  logic [15:0] core_sin = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_cos;
  logic [31:0] rsp_sin;
  logic        core_timeout;

  int checks = 0;
  int errors = 0;

  cordic_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_phase(req_phase), .req_quadrant(req_quadrant),
    .core_start(core_start), .core_phase(core_phase),
    .core_done(core_done), .core_cos(core_cos), .core_sin(core_sin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
    .core_timeout(core_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // Reference arithmetic: saturating negation on signed 16-bit values.
  function automatic logic [15:0] ref_neg(input logic [15:0] x);
    int v;
    v = $signed(x);
    v = -v;
    if (v > 32767) v = 32767;
    return v[15:0];
  endfunction

  function automatic logic [15:0] ref_cos(input int q, input logic [15:0] c);
    return (q == 1 || q == 2) ? ref_neg(c) : c;
  endfunction

  function automatic logic [15:0] ref_sin(input int q, input logic [15:0] s);
    return (q == 2 || q == 3) ? ref_neg(s) : s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; core_done = 1'b0;
    req_phase = '0; req_quadrant = '0; core_cos = '0; core_sin = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b expected 0", core_start); end
    checks++; if (core_phase !== 13'd0) begin errors++; $display("FAIL reset_core_phase: got %0d expected 0", core_phase); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_cos !== 32'd0 || rsp_sin !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h/%h expected 0/0", rsp_cos, rsp_sin); end
    checks++; if (core_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", core_timeout); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_idle: got %b expected 00", req_ready); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_pointer: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    $display("test_reset done");
  endtask

  task automatic test_quadrant_ii();
    do_reset();
    req_valid = 2'b01; req_phase = {13'd0, 13'd1000}; req_quadrant = 4'b0001;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL q2_grant: got %b expected 01", req_ready); end
    tick(); req_valid = 2'b00; #1;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL q2_start: got %b expected 1", core_start); end
    checks++; if (core_phase !== 13'd1000) begin errors++; $display("FAIL q2_phase: got %0d expected 1000", core_phase); end
    tick(); #1;
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL q2_start_pulse: got %b expected 0", core_start); end
    tick(); core_done = 1'b1; core_cos = 16'h1000; core_sin = 16'h0800; #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL q2_early_valid: got %b expected 00", rsp_valid); end
    tick(); core_done = 1'b0; core_cos = 16'h1234; core_sin = 16'h4321; #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL q2_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_cos[15:0] !== 16'hF000) begin errors++; $display("FAIL q2_cos: got %h expected f000", rsp_cos[15:0]); end
    checks++; if (rsp_sin[15:0] !== 16'h0800) begin errors++; $display("FAIL q2_sin: got %h expected 0800", rsp_sin[15:0]); end
    $display("txn ch=0 quad=II phase=1000 cos=%h sin=%h", rsp_cos[15:0], rsp_sin[15:0]);
    tick(); #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL q2_hold: got %b expected 01", rsp_valid); end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00; #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL q2_release: got %b expected 00", rsp_valid); end
    checks++; if (rsp_cos[15:0] !== 16'hF000) begin errors++; $display("FAIL q2_data_hold: got %h expected f000", rsp_cos[15:0]); end
  endtask

  task automatic test_saturation();
    do_reset();
    req_valid = 2'b10; req_phase = {13'd3216, 13'd0}; req_quadrant = 4'b1000;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sat_grant: got %b expected 10", req_ready); end
    tick(); req_valid = 2'b00; #1;
    checks++; if (core_phase !== 13'd3216) begin errors++; $display("FAIL sat_phase: got %0d expected 3216", core_phase); end
    tick(); core_done = 1'b1; core_cos = 16'h8000; core_sin = 16'h7FFF; #1;
    tick(); core_done = 1'b0; #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL sat_valid: got %b expected 10", rsp_valid); end
    checks++; if (rsp_cos[31:16] !== 16'h7FFF) begin errors++; $display("FAIL sat_cos: got %h expected 7fff", rsp_cos[31:16]); end
    checks++; if (rsp_sin[31:16] !== 16'h8001) begin errors++; $display("FAIL sat_sin: got %h expected 8001", rsp_sin[31:16]); end
    checks++; if (rsp_cos[15:0] !== 16'h0000) begin errors++; $display("FAIL sat_other_ch: got %h expected 0000", rsp_cos[15:0]); end
    $display("txn ch=1 quad=III cos=%h sin=%h", rsp_cos[31:16], rsp_sin[31:16]);
  endtask

  task automatic test_round_robin();
    logic       started;
    logic [1:0] exp_rdy;
    do_reset();
    started = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11; req_quadrant = 4'b0000;
    for (int cyc = 0; cyc < 12; cyc++) begin
      core_done = started; core_cos = 16'($urandom); core_sin = 16'($urandom);
      req_phase = 26'($urandom);
      #1;
      exp_rdy = (cyc % 3 != 0) ? 2'b00 : (((cyc / 3) % 2 == 1) ? 2'b10 : 2'b01);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_cycle%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
      if (req_ready != 2'b00) $display("txn rr grant=%b cycle=%0d", req_ready, cyc);
      started = core_start;
      tick();
    end
    core_done = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_pending();
    logic started;
    int   n1;
    bit   found;
    do_reset();
    started = 1'b0; n1 = 0; found = 0;
    req_valid = 2'b11; rsp_ready = 2'b10; req_quadrant = 4'b0000;
    for (int cyc = 0; cyc < 16; cyc++) begin
      core_done = started; core_cos = 16'($urandom); core_sin = 16'($urandom);
      #1;
      if (cyc == 0) begin
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL pend_first: got %b expected 01", req_ready); end
      end else begin
        checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL pend_ch0_blocked%0d: got %b expected x0", cyc, req_ready); end
      end
      if (req_ready == 2'b10) n1++;
      started = core_start;
      tick();
    end
    checks++; if (n1 !== 4) begin errors++; $display("FAIL pend_ch1_count: got %0d expected 4", n1); end
    $display("txn pending ch1_grants=%0d", n1);
    for (int i = 0; i < 10 && !found; i++) begin
      core_done = started;
      #1;
      started = core_start;
      if (rsp_valid[1]) begin
        found = 1;
        rsp_ready = 2'b11;
      end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL pend_wait: got no ch1 result expected one within 10 cycles"); end
    core_done = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL pend_regrant: got %b expected 01", req_ready); end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  task automatic test_reset_midjob();
    rsp_ready = 2'b11; tick(); rsp_ready = 2'b00;
    req_valid = 2'b01; req_phase = {13'd0, 13'd555}; req_quadrant = 4'b0010;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b expected 01", req_ready); end
    tick(); req_valid = 2'b00;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (core_phase !== 13'd0 || core_start !== 1'b0) begin errors++; $display("FAIL mid_core: got %0d/%b expected 0/0", core_phase, core_start); end
    checks++; if (rsp_valid !== 2'b00 || rsp_cos !== 32'd0 || rsp_sin !== 32'd0) begin errors++; $display("FAIL mid_rsp: got %b %h %h expected 00 0 0", rsp_valid, rsp_cos, rsp_sin); end
    tick(); rst = 1'b0; core_done = 1'b1; core_cos = 16'h2222; core_sin = 16'h3333;
    tick(); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_stray_done: got %b expected 00", rsp_valid); end
    core_done = 1'b0;
    tick(); #1;
    checks++; if (rsp_valid !== 2'b00 || core_start !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b/%b expected 00/0", rsp_valid, core_start); end
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_idle_ready: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    $display("test_reset_midjob done");
  endtask

  task automatic test_random();
    int          mstate;   // 0 idle, 1 issue, 2 wait
    int          rr_ptr, jch, jq, wcnt, g;
    logic [12:0] jphase;
    logic [1:0]  pend, el, exp_rdy, rel;
    logic [15:0] ec0, ec1, es0, es1;
    do_reset();
    mstate = 0; rr_ptr = 0; jch = 0; jq = 0; wcnt = 0; jphase = '0;
    pend = '0; ec0 = '0; ec1 = '0; es0 = '0; es1 = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid    = 2'($urandom);
      rsp_ready    = 2'($urandom);
      req_phase    = {13'($urandom_range(0, 3216)), 13'($urandom_range(0, 3216))};
      req_quadrant = 4'($urandom);
      core_cos     = ($urandom % 6 == 0) ? 16'h8000 : 16'($urandom);
      core_sin     = ($urandom % 6 == 0) ? 16'h8000 : 16'($urandom);
      core_done    = (mstate == 2) ? (wcnt == 0) : ($urandom % 4 == 0);
      #1;
      el = req_valid & ~pend;
      g = -1;
      if (mstate == 0 && el != 2'b00) g = (el == 2'b11) ? rr_ptr : (el[1] ? 1 : 0);
      exp_rdy = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
      checks++; if (core_start !== (mstate == 1)) begin errors++; $display("FAIL rnd_start%0d: got %b expected %b", cyc, core_start, mstate == 1); end
      checks++; if (core_phase !== jphase) begin errors++; $display("FAIL rnd_phase%0d: got %0d expected %0d", cyc, core_phase, jphase); end
      checks++; if (rsp_valid !== pend) begin errors++; $display("FAIL rnd_valid%0d: got %b expected %b", cyc, rsp_valid, pend); end
      checks++; if (rsp_cos !== {ec1, ec0}) begin errors++; $display("FAIL rnd_cos%0d: got %h expected %h", cyc, rsp_cos, {ec1, ec0}); end
      checks++; if (rsp_sin !== {es1, es0}) begin errors++; $display("FAIL rnd_sin%0d: got %h expected %h", cyc, rsp_sin, {es1, es0}); end
      rel = pend & rsp_ready;
      pend = pend & ~rel;
      if (g >= 0) begin
        jch = g; jq = (g == 1) ? int'(req_quadrant[3:2]) : int'(req_quadrant[1:0]);
        jphase = (g == 1) ? req_phase[25:13] : req_phase[12:0];
        rr_ptr = 1 - g; mstate = 1;
        $display("txn rnd grant ch=%0d quad=%0d phase=%0d", jch, jq, jphase);
      end else if (mstate == 1) begin
        mstate = 2; wcnt = $urandom_range(0, 3);
      end else if (mstate == 2) begin
        if (core_done) begin
          if (jch == 1) begin ec1 = ref_cos(jq, core_cos); es1 = ref_sin(jq, core_sin); end
          else          begin ec0 = ref_cos(jq, core_cos); es0 = ref_sin(jq, core_sin); end
          pend[jch] = 1'b1; mstate = 0;
        end else begin
          wcnt--;
        end
      end
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b00; core_done = 1'b0;
  endtask

`ifdef CORDIC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_valid = 2'b01; req_quadrant = 4'b0000; req_phase = {13'd0, 13'd77};
    tick(); req_valid = 2'b00;
    tick(); core_done = 1'b1; core_cos = 16'h1111; core_sin = 16'h2222;
    tick(); core_done = 1'b0; rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL to_grant: got %b expected 01", req_ready); end
    tick(); req_valid = 2'b00;
    tick();
    for (int i = 0; i < 64; i++) begin
      #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL to_early%0d: got %b expected 00", i, rsp_valid); end
      tick();
    end
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL to_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_cos[15:0] !== 16'd0 || rsp_sin[15:0] !== 16'd0) begin errors++; $display("FAIL to_zero: got %h/%h expected 0/0", rsp_cos[15:0], rsp_sin[15:0]); end
    checks++; if (core_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", core_timeout); end
    rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
    req_valid = 2'b01; tick(); req_valid = 2'b00;
    tick(); core_done = 1'b1; core_cos = 16'h0123; core_sin = 16'h0456;
    tick(); core_done = 1'b0; #1;
    checks++; if (rsp_cos[15:0] !== 16'h0123 || core_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %h/%b expected 0123/1", rsp_cos[15:0], core_timeout); end
    $display("txn timeout job complete");
  endtask
`endif

  initial begin
    test_reset();
    test_quadrant_ii();
    test_saturation();
    test_reset_midjob();
    test_round_robin();
    test_pending();
    test_random();
`ifdef CORDIC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
